// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-to-serial shifter with active-low EN strobe.
// Defining PISO_SERIALIZER_PARITY_EN appends an even-parity cycle after the data bits.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load,
  output logic             ready,
  output logic             s_out,
  output logic             EN,
  output logic             done,
  output logic             par_vld
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_SERIALIZER_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic par_q, par_d;
`endif
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d = par_q;
`endif
    if (state_q == IDLE && load) begin
      state_d = SHIFT;
      sr_d = p_in;
      cnt_d = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_d = ^p_in;
`endif
    end else if (state_q == SHIFT) begin
      sr_d = sr_q << 1;
      if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PISO_SERIALIZER_PARITY_EN
        state_d = PARITY;
`else
        state_d = IDLE;
        done_d = 1'b1;
`endif
      end else cnt_d = cnt_q + CW'(1);
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    else if (state_q == PARITY) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  assign ready = state_q == IDLE;
  assign EN = state_q != SHIFT;
  assign done = done_q;
`ifdef PISO_SERIALIZER_PARITY_EN
  assign s_out = (state_q == SHIFT) ? sr_q[WIDTH-1] : (state_q == PARITY) && par_q;
  assign par_vld = state_q == PARITY;
`else
  assign s_out = (state_q == SHIFT) && sr_q[WIDTH-1];
  assign par_vld = 1'b0;
`endif
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized scoreboard bench with a word-level reference model.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic load_i = 1'b0;
  logic [W-1:0] p_i = '0;
  logic ready, s_out, EN, done, par_vld;
  logic [W-1:0] sipo;
  int total = 0;
  int passed = 0;
  int rem = 0;
  logic exp_ready = 1'b1;
  bit mon_en = 1'b0;
  typedef struct {
    int kind;
    logic [31:0] val;
  } item_t;
  item_t q[$];

  piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .RST(rst_i), .p_in(p_i), .load(load_i),
    .ready(ready), .s_out(s_out), .EN(EN), .done(done), .par_vld(par_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_i) sipo <= '0;
    else if (!EN) sipo <= {sipo[W-2:0], s_out};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cycle(input logic r, input logic l, input logic [W-1:0] d);
    rst_i = r;
    load_i = l;
    p_i = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      rem = 0;
    end else if (l && rem == 0) begin
      for (int i = W - 1; i >= 0; i--) q.push_back('{0, 32'((d >> i) & 1)});
      if (P == 1) q.push_back('{1, 32'(^d)});
      q.push_back('{2, 32'(d)});
      rem = W + P;
    end else if (rem > 0) rem--;
    exp_ready = rem == 0;
    mon_en = 1'b1;
    #1;
  endtask

  always @(negedge clk) if (mon_en) begin
    item_t it;
    int kind;
    chk("ready", 32'(ready), 32'(exp_ready));
    chk("par_vld_mode", 32'(par_vld && P == 0), 32'd0);
    if (!EN || par_vld || done) begin
      if (q.size() == 0) chk("unexpected_activity", 32'({EN, par_vld, done}), 32'b100);
      else begin
        it = q.pop_front();
        kind = done ? 2 : (par_vld ? 1 : 0);
        chk("event_kind", 32'(kind), 32'(it.kind));
        if (it.kind < 2) chk(it.kind == 0 ? "data_bit" : "parity_bit", 32'(s_out), it.val);
        else chk("sipo_word", 32'(sipo), it.val);
        if (it.kind == 1) chk("parity_en", 32'(EN), 32'd1);
      end
    end else chk("idle_s_out", 32'(s_out), 32'd0);
  end

  initial begin
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 8'hAA);
    repeat (2) cycle(1'b0, 1'b0, '0);
    chk("reset_idle", 32'({ready, EN, s_out, done, par_vld}), 32'b11000);
    cycle(1'b0, 1'b1, 8'hB4);
    repeat (W + P + 1) cycle(1'b0, 1'b1, 8'h5A);
    repeat (W + P + 3) cycle(1'b0, 1'b0, 8'h33);
    cycle(1'b0, 1'b1, 8'hFF);
    repeat (3) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("abort_idle", 32'({ready, EN, done}), 32'b110);
    cycle(1'b0, 1'b1, 8'h01);
    repeat (W + P + 2) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h07);
    repeat (W + P + 2) cycle(1'b0, 1'b0, '0);
    for (int n = 0; n < 800; n++)
      cycle(($urandom % 70) == 0, ($urandom % 3) != 0, W'($urandom));
    repeat (W + P + 3) cycle(1'b0, 1'b0, '0);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the parallel word width (legal values 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 p_in  input  WIDTH  SHALL carry the parallel word to be serialized.
REQ-005 load  input  1  SHALL request transmission of p_in; it is accepted only when ready=1.
REQ-006 ready  output  1  SHALL indicate the block is idle and can accept load.
REQ-007 s_out  output  1  SHALL carry the serial data stream.
REQ-008 EN  output  1  SHALL be the active-low shift enable for the downstream serial-in register: 0 while a data bit is on s_out, else 1.
REQ-009 done  output  1  SHALL pulse high for one cycle when a word completes.
REQ-010 par_vld  output  1  SHALL flag that s_out carries the parity bit.

Function
REQ-011 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-012 States SHALL be IDLE, SHIFT and PARITY; PARITY is reachable only with the REQ-026 macro.
REQ-013 IDLE: ready=1, EN=1, s_out=0, done=0, par_vld=0.
REQ-014 load=1 sampled in IDLE at edge k SHALL latch p_in into an internal shift register, clear the bit counter, enter SHIFT and drop ready.
REQ-015 After edge k, s_out SHALL equal p_in[WIDTH-1] and EN SHALL be 0; each later edge in SHIFT SHALL shift the MSB out, so bits leave MSB first.
REQ-016 The last bit (p_in[0]) SHALL be on s_out during the cycle after edge k+WIDTH-1.
REQ-017 At edge k+WIDTH, the block SHALL leave SHIFT: without parity, go to IDLE with done=1, EN=1, ready=1.
REQ-018 done SHALL be high for exactly one cycle and SHALL be 0 otherwise.
REQ-019 load in any state other than IDLE SHALL be ignored; p_in changes after acceptance SHALL NOT affect the word in flight.
REQ-020 A load asserted in the same cycle that done=1 SHALL be accepted, giving back-to-back words with one idle cycle (EN=1) between them.
REQ-021 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within a word.
REQ-022 A downstream register that shifts on EN=0 SHALL end with its element 0 holding p_in[0] and element WIDTH-1 holding p_in[WIDTH-1].

Reset
REQ-023 RST=1 at a rising edge SHALL force IDLE: ready=1, EN=1, s_out=0, done=0, par_vld=0, counter=0, shift register=0.
REQ-024 RST mid-word SHALL abort the word with no done pulse; RST SHALL take priority over load in the same cycle.
REQ-025 With RST held high, load SHALL be ignored.

Configuration
REQ-026 With macro PISO_SERIALIZER_PARITY_EN defined, after edge k+WIDTH the block SHALL enter PARITY for one cycle: s_out = XOR of the latched word (even parity), par_vld=1, EN=1; done SHALL be asserted at edge k+WIDTH+1 on return to IDLE.
REQ-027 Without PISO_SERIALIZER_PARITY_EN, the PARITY state and the parity logic SHALL be absent and par_vld SHALL be constant 0.

Verification
REQ-028 RST=1 for 2 cycles, then RST=0, load=0 -> ready=1, EN=1, s_out=0, done=0, par_vld=0.
REQ-029 p_in=8'hB4, load for 1 cycle -> s_out=1,0,1,1,0,1,0,0 on 8 consecutive cycles with EN=0; then EN=1 and done=1 for one cycle.
REQ-030 Feed s_out/EN/clk/RST to the 8-bit serial-in register: after the REQ-029 sequence its parallel output SHALL equal the bit pattern 1,0,1,1,0,1,0,0 in element order 7..0.
REQ-031 Word 8'hB4, then load=1 with p_in=8'h5A held continuously during the first word -> the second word starts at the done cycle; 8'h5A SHALL be transmitted intact.
REQ-032 Assert RST at the 4th bit of 8'hFF -> next cycle IDLE, EN=1, no done; then a fresh load of 8'h01 -> 0,0,0,0,0,0,0,1.
REQ-033 PISO_SERIALIZER_PARITY_EN defined, p_in=8'h07 -> 8 data bits, then one cycle with s_out=1, par_vld=1, EN=1, then done=1; without the macro, par_vld stays 0 throughout.
